// File: rtl/memq_pkg.sv
// memq_pkg: widths, size and FSM encodings, queue entry type and lane helpers for memq.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Ports: none (package).
package memq_pkg;

  localparam int XLEN     = 32;
  localparam int RGBIT    = 5;
  localparam int MEMQ_LEN = 4;
  localparam int PTR_W    = $clog2(MEMQ_LEN);
  localparam int CNT_W    = $clog2(MEMQ_LEN + 1);

  // Access size encodings; 2'd3 behaves as a word everywhere.
  localparam logic [1:0] MEMQ_BYTE = 2'd0;
  localparam logic [1:0] MEMQ_HALF = 2'd1;
  localparam logic [1:0] MEMQ_WORD = 2'd2;

  // Head FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic             load;
    logic [1:0]       size;
    logic             uns;
    logic [RGBIT-1:0] rd;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
  } memq_entry_t;

  // Byte enables for a 32-bit data bus.
  function automatic logic [3:0] memq_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      MEMQ_BYTE: be = 4'b0001 << lo;
      MEMQ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the slave can pick by byte enable.
  function automatic logic [XLEN-1:0] memq_wrep(input logic [1:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (size)
      MEMQ_BYTE: w = {4{d[7:0]}};
      MEMQ_HALF: w = {2{d[15:0]}};
      default:   w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memq_if.sv
// memq_if: bundles the execute-side request, data-memory bus and write-back signals of memq.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side; dmem_req held until dmem_gnt on the bus.
// Modports: slave = memq itself; master = the surrounding execute stage, bus and register file.
interface memq_if;
  import memq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [RGBIT-1:0] req_rd;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             clear_pipeline;

  logic             dmem_req;
  logic             dmem_we;
  logic [XLEN-1:0]  dmem_addr;
  logic [3:0]       dmem_be;
  logic [XLEN-1:0]  dmem_wdata;
  logic             dmem_gnt;
  logic             dmem_rvalid;
  logic [XLEN-1:0]  dmem_rdata;

  logic             mem_release;
  logic [RGBIT-1:0] mem_sel;
  logic [XLEN-1:0]  mem_data;
  logic [CNT_W-1:0] memq_num;

  modport slave (
    input  req_valid, req_load, req_size, req_unsigned, req_rd, req_addr, req_wdata,
           clear_pipeline, dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           mem_release, mem_sel, mem_data, memq_num
  );

  modport master (
    output req_valid, req_load, req_size, req_unsigned, req_rd, req_addr, req_wdata,
           clear_pipeline, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           mem_release, mem_sel, mem_data, memq_num
  );

endinterface

// File: rtl/memq_ext.sv
// memq_ext: picks the addressed lane of a read word and sign/zero extends it to XLEN.
// Latency: combinational.
// Backpressure: none.
// Ports: size, uns, addr_lo (addr[1:0]), rdata in; data out.
module memq_ext
  import memq_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    // Halfwords only look at addr[1]; addr[0] is don't-care.
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEMQ_BYTE: data = {{24{lane_b[7] & ~uns}}, lane_b};
      MEMQ_HALF: data = {{16{lane_h[15] & ~uns}}, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/memq.sv
// memq: in-order load/store queue issuing one op at a time to the data bus and producing write-back pulses.
// Latency: accepted op requests the bus 2 cycles later (1 with MEMQ_BYPASS_EN into an idle empty queue);
//          write-back pulse is registered, one cycle after dmem_rvalid.
// Backpressure: req_ready drops when the registered count is full or during clear_pipeline; dmem_req held until dmem_gnt.
// Ports: clk, rst (async active-high), mq (memq_if.slave). Optional macro: MEMQ_BYPASS_EN.
module memq
  import memq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  memq_if.slave  mq
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEMQ_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  memq_entry_t      mem [MEMQ_LEN];
  memq_entry_t      head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             ready;
  logic             push;
  logic             pop;
  logic             issuing;
  logic [XLEN-1:0]  ext_data;
  logic             rel_q;
  logic [RGBIT-1:0] sel_q;
  logic [XLEN-1:0]  data_q;

  assign head    = mem[rd_ptr];
  // Registered count only: a push into a full queue is refused even when a pop lands the same edge.
  assign ready   = (cnt < CNT_FULL) & ~mq.clear_pipeline;
  assign push    = mq.req_valid & ready;
  assign pop     = (state == ST_WAIT) & mq.dmem_rvalid;
  assign issuing = (state == ST_REQ);

  assign mq.req_ready   = ready;
  assign mq.memq_num    = cnt;
  assign mq.dmem_req    = issuing;
  // Bus fields are gated so they read zero outside a request (storage is not reset).
  assign mq.dmem_we     = issuing & ~head.load;
  assign mq.dmem_addr   = issuing ? {head.addr[XLEN-1:2], 2'b00} : '0;
  assign mq.dmem_be     = issuing ? memq_be(head.size, head.addr[1:0]) : 4'b0000;
  assign mq.dmem_wdata  = issuing ? memq_wrep(head.size, head.wdata) : '0;
  assign mq.mem_release = rel_q;
  assign mq.mem_sel     = sel_q;
  assign mq.mem_data    = data_q;

  memq_ext u_ext (
    .size    (head.size),
    .uns     (head.uns),
    .addr_lo (head.addr[1:0]),
    .rdata   (mq.dmem_rdata),
    .data    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{load: mq.req_load, size: mq.req_size, uns: mq.req_unsigned,
                       rd: mq.req_rd, addr: mq.req_addr, wdata: mq.req_wdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef MEMQ_BYPASS_EN
          // Start the request on the same edge that fills an empty queue.
          if ((cnt != '0) || push) state <= ST_REQ;
`else
          if (cnt != '0) state <= ST_REQ;
`endif
        end
        ST_REQ:  if (mq.dmem_gnt) state <= ST_WAIT;
        // cnt still includes the entry being popped, hence > 1.
        ST_WAIT: if (mq.dmem_rvalid) state <= (cnt > CNT_ONE) ? ST_REQ : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_q  <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      rel_q  <= pop;
      sel_q  <= (pop & head.load) ? head.rd : '0;
      data_q <= (pop & head.load) ? ext_data : '0;
    end
  end

endmodule
